dppm_decoder: RTL and testbench

//  Receive-side D-PPM stage, downstream of the LED encoder across the optical link.

---
 rtl/dppm_decoder.sv | 194 +++++++++++++++++++
 tb/tb_dppm_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dppm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : dppm_decoder
// Description : Receive-side D-PPM decoder. Synchronises the photodetector
//               line, measures the gap between successive rising edges and
//               classifies each gap as bit 0 / bit 1. A complete frame of
//               FRAME_SIZE bits (LSB first) is presented with a valid/ack
//               handshake. A bad gap or a missing pulse gives a 1-cycle
//               error pulse.
//               Optional macro DPPM_DECODER_STATS_EN adds saturating
//               frame_count / error_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dppm_decoder #(
    parameter int FRAME_SIZE    = 32,
    parameter int INTERVAL_LOW  = 8,
    parameter int INTERVAL_HIGH = 16,
    parameter int TOLERANCE     = 2,
    parameter int COUNTER_SIZE  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sensor,
    output logic [FRAME_SIZE-1:0] data,
    output logic                  frame_valid,
    input  logic                  ack,
    output logic                  error
`ifdef DPPM_DECODER_STATS_EN
    ,
    output logic [15:0]           frame_count,
    output logic [15:0]           error_count
`endif
);

    localparam int IDX_W   = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam int GAP_LOW = INTERVAL_LOW + 1;
    localparam int GAP_HIGH = INTERVAL_HIGH + 1;

    localparam logic [COUNTER_SIZE-1:0] C_LOW_MIN  = COUNTER_SIZE'(GAP_LOW - TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] C_LOW_MAX  = COUNTER_SIZE'(GAP_LOW + TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] C_HIGH_MIN = COUNTER_SIZE'(GAP_HIGH - TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] C_HIGH_MAX = COUNTER_SIZE'(GAP_HIGH + TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] C_TIMEOUT  = COUNTER_SIZE'(GAP_HIGH + TOLERANCE + 1);
    localparam logic [IDX_W-1:0]        C_LAST_IDX = IDX_W'(FRAME_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    sync1_q;
    logic                    sync2_q;
    logic                    prev_q;
    logic [COUNTER_SIZE-1:0] cnt_q;
    logic [COUNTER_SIZE-1:0] cnt_d;
    logic [IDX_W-1:0]        idx_q;
    logic [FRAME_SIZE-1:0]   data_q;
    logic                    frame_valid_q;
    logic                    error_q;

    logic                    pulse_edge;
    logic                    gap_is_zero;
    logic                    gap_is_one;
    logic                    gap_good;
    logic                    frame_done;
    logic                    error_event;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sensor;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_edge = sync2_q & ~prev_q;

    // Gap classification and events that leave RECV
    always_comb begin
        gap_is_zero = (cnt_q >= C_LOW_MIN)  && (cnt_q <= C_LOW_MAX);
        gap_is_one  = (cnt_q >= C_HIGH_MIN) && (cnt_q <= C_HIGH_MAX);
        gap_good    = gap_is_zero | gap_is_one;
        frame_done  = enable && (state_q == RECV) && pulse_edge && gap_good
                      && (idx_q == C_LAST_IDX);
        // An edge takes precedence over a coincident timeout
        error_event = enable && (state_q == RECV) &&
                      (pulse_edge ? !gap_good : (cnt_q == C_TIMEOUT));
    end

    // Gap counter next value: restart at 1 on an edge, otherwise saturating +1
    always_comb begin
        cnt_d = cnt_q;
        if (pulse_edge) begin
            cnt_d = COUNTER_SIZE'(1);
        end else if (cnt_q != {COUNTER_SIZE{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Gap counter register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Receiver FSM with registered data/frame_valid/error outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            error_q <= 1'b0;
            // A held frame may be acknowledged even after enable has dropped
            if (ack && frame_valid_q) begin
                frame_valid_q <= 1'b0;
            end
            if (!enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        // First edge is only the timing reference
                        if (pulse_edge) begin
                            idx_q   <= '0;
                            state_q <= RECV;
                        end
                    end
                    RECV: begin
                        if (error_event) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else if (pulse_edge) begin
                            data_q[idx_q] <= gap_is_one;
                            idx_q         <= idx_q + 1'b1;
                            if (frame_done) begin
                                frame_valid_q <= 1'b1;
                                state_q       <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (ack) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data        = data_q;
    assign frame_valid = frame_valid_q;
    assign error       = error_q;

`ifdef DPPM_DECODER_STATS_EN
    logic [15:0] frame_count_q;
    logic [15:0] error_count_q;

    // Saturating frame and error statistics
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            if (frame_done && (frame_count_q != 16'hFFFF)) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
            if (error_event && (error_count_q != 16'hFFFF)) begin
                error_count_q <= error_count_q + 1'b1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dppm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dppm_decoder
// Description : Scoreboard bench for dppm_decoder. A transmitter model drives
//               pulse trains; expected frames and error pulses (with the
//               cycle they should appear) are queued, and a monitor compares
//               them against the DUT outputs. Build with
//               DPPM_DECODER_STATS_EN to also check the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dppm_decoder;

    localparam int FS    = 32;
    localparam int IL    = 8;
    localparam int IH    = 16;
    localparam int TOL   = 2;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b1;
    logic          sensor  = 1'b0;
    logic          ack     = 1'b0;
    logic [FS-1:0] data;
    logic          frame_valid;
    logic          error;
`ifdef DPPM_DECODER_STATS_EN
    logic [15:0]   frame_count;
    logic [15:0]   error_count;
`endif

    dppm_decoder #(
        .FRAME_SIZE   (FS),
        .INTERVAL_LOW (IL),
        .INTERVAL_HIGH(IH),
        .TOLERANCE    (TOL),
        .COUNTER_SIZE (8)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .sensor      (sensor),
        .data        (data),
        .frame_valid (frame_valid),
        .ack         (ack),
        .error       (error)
`ifdef DPPM_DECODER_STATS_EN
        ,
        .frame_count (frame_count),
        .error_count (error_count)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [FS-1:0] d;
        int            c;
    } exp_t;

    exp_t fq[$];
    int   eq[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_frames   = 0;
    int   n_errors   = 0;
    int   last_p     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare frames and error pulses against the scoreboard
    initial begin : monitor
        logic          fv_prev;
        logic [FS-1:0] cur_d;
        exp_t          e;
        int            c;
        fv_prev = 1'b0;
        cur_d   = '0;
        forever begin
            @(negedge clock);
            if (frame_valid && !fv_prev) begin
                if (fq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame: got data %0h expected no frame (cycle %0d)", data, cyc);
                end else begin
                    e = fq.pop_front();
                    check("frame_data", data, e.d);
                    check("frame_latency", cyc, e.c);
                    cur_d = e.d;
                end
            end else if (frame_valid) begin
                check("data_hold", data, cur_d);
            end
            if (error) begin
                if (eq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_error: got error=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    c = eq.pop_front();
                    check("error_cycle", cyc, c);
                end
            end
            fv_prev = frame_valid;
        end
    end

    // Transmitter model: gap for a bit value, randomly within tolerance
    function automatic int rand_gap(input logic b);
        int nominal;
        nominal = b ? (IH + 1) : (IL + 1);
        return nominal - TOL + int'($urandom_range(0, 2 * TOL));
    endfunction

    // Drive a 1-cycle pulse; caller is positioned just after a posedge
    task automatic pulse_now();
        sensor = 1'b1;
        last_p = cyc;
        @(posedge clock);
        #1 sensor = 1'b0;
    endtask

    // Next pulse exactly g cycles after the previous one
    task automatic gap_pulse(input int g);
        repeat (g - 1) @(posedge clock);
        #1;
        pulse_now();
    endtask

    task automatic start_pulse();
        @(posedge clock);
        #1;
        pulse_now();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Full frame: start reference then FS bits, LSB first
    task automatic send_frame(input logic [FS-1:0] w);
        exp_t e;
        start_pulse();
        for (int i = 0; i < FS; i++) begin
            gap_pulse(rand_gap(w[i]));
        end
        e.d = w;
        e.c = last_p + 3;
        fq.push_back(e);
        n_frames++;
    endtask

    task automatic send_partial(input int nbits);
        start_pulse();
        for (int i = 0; i < nbits; i++) begin
            gap_pulse(rand_gap(1'($urandom_range(0, 1))));
        end
    endtask

    // Wait (bounded) for frame_valid, then acknowledge it
    task automatic do_ack();
        int waited;
        waited = 0;
        while (!frame_valid && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("valid_before_ack", frame_valid, 1'b1);
        @(posedge clock);
        #1 ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ack_clear", frame_valid, 1'b0);
        ack = 1'b0;
        idle_cycles(5);
    endtask

    initial begin : stimulus
        int waited;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_data", data, '0);
        check("reset_valid", frame_valid, 1'b0);
        check("reset_error", error, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle_cycles(4);

        // Known frame
        send_frame(32'hA5A5_0F0F);
        idle_cycles(8);
        do_ack();

        // Tolerance edges accepted, gap 12 rejected
        start_pulse();
        gap_pulse(7);
        gap_pulse(11);
        gap_pulse(15);
        gap_pulse(19);
        gap_pulse(12);
        eq.push_back(last_p + 3);
        n_errors++;
        idle_cycles(30);
        check("valid_after_bad_gap", frame_valid, 1'b0);

        // Pulses stop after 5 bits -> timeout, then recovery
        send_partial(5);
        eq.push_back(last_p + 23);
        n_errors++;
        idle_cycles(40);
        send_frame(FS'($urandom));
        idle_cycles(8);
        do_ack();

        // Frame held without ack while pulses continue
        send_frame(FS'($urandom));
        idle_cycles(8);
        for (int i = 0; i < 6; i++) begin
            gap_pulse(9);
        end
        idle_cycles(8);
        do_ack();

        // Reset in the middle of bit 17
        send_partial(17);
        idle_cycles(2);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("midreset_data", data, '0);
        check("midreset_valid", frame_valid, 1'b0);
        check("midreset_error", error, 1'b0);
`ifdef DPPM_DECODER_STATS_EN
        check("midreset_frame_count", frame_count, 16'd0);
        check("midreset_error_count", error_count, 16'd0);
        n_frames = 0;
        n_errors = 0;
`endif
        idle_cycles(4);
        send_frame(FS'($urandom));
        idle_cycles(8);
        do_ack();

        // enable dropped mid-frame: back to IDLE without an error
        send_partial(3);
        idle_cycles(2);
        enable = 1'b0;
        idle_cycles(3);
        enable = 1'b1;
        idle_cycles(30);
        send_frame(FS'($urandom));
        idle_cycles(8);
        do_ack();

        // Random frames, plus one more bad gap
        for (int k = 0; k < 3; k++) begin
            send_frame(FS'($urandom));
            idle_cycles(8);
            do_ack();
        end
        send_partial(4);
        gap_pulse(13);
        eq.push_back(last_p + 3);
        n_errors++;
        idle_cycles(30);

        // Drain scoreboard (bounded)
        waited = 0;
        while ((fq.size() + eq.size()) != 0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("scoreboard_drained", fq.size() + eq.size(), 0);
`ifdef DPPM_DECODER_STATS_EN
        check("frame_count", frame_count, 16'(n_frames));
        check("error_count", error_count, 16'(n_errors));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
